// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the arbiter, the two pipeline requesters (IF, MEM) and the shared memory.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;
   logic              flush;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, flush, mem_rdata, mem_ack,
      output if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, flush, mem_rdata, mem_ack,
      input  if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and data stages: data wins by default,
// a starvation counter forces fetch grants, and a flush drops an in-flight fetch.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   mem_port_arbiter_if.slave   bus
);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY, IF_DROP} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_starve_cnt;
   logic [CNT_W-1:0]   w_starve_nxt;
   logic               w_if_elig;
   logic               w_d_elig;
   logic               w_grant_d;
   logic               w_grant_if;
   logic               w_if_done;
   logic               w_d_done;

   logic               r_mem_req;
   logic               r_mem_we;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [DATA_W-1:0]  r_mem_wdata;
   logic [DATA_W-1:0]  r_if_rdata;
   logic               r_if_ready;
   logic [DATA_W-1:0]  r_d_rdata;
   logic               r_d_ready;

   // A requester whose ready is high this cycle is finishing, not asking again.
   always_comb begin
      w_if_elig   = bus.if_req & ~r_if_ready;
      w_d_elig    = bus.d_req  & ~r_d_ready;
      w_grant_d   = 1'b0;
      w_grant_if  = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_d_elig && (!w_if_elig || (r_starve_cnt < CNT_W'(STARVE_MAX)))) begin
               w_grant_d   = 1'b1;
               w_state_nxt = D_BUSY;
            end else if (w_if_elig && !bus.flush) begin
               w_grant_if  = 1'b1;
               w_state_nxt = IF_BUSY;
            end
         end
         IF_BUSY: begin
            if (bus.mem_ack)    w_state_nxt = IDLE;
            else if (bus.flush) w_state_nxt = IF_DROP;
         end
         D_BUSY, IF_DROP: begin
            if (bus.mem_ack) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_starve_nxt = r_starve_cnt;
      if (!bus.if_req || w_grant_if)
         w_starve_nxt = '0;
      else if (w_grant_d && (r_starve_cnt < CNT_W'(STARVE_MAX)))
         w_starve_nxt = r_starve_cnt + CNT_W'(1);
   end

   assign w_if_done = (r_state == IF_BUSY) && bus.mem_ack && !bus.flush;
   assign w_d_done  = (r_state == D_BUSY)  && bus.mem_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_starve_cnt <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_nxt;
      end
   end

   // The grant edge latches the winning request; mem_req then holds until the ack cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rdata  <= '0;
         r_if_ready  <= 1'b0;
         r_d_rdata   <= '0;
         r_d_ready   <= 1'b0;
      end else begin
         r_if_ready <= w_if_done;
         r_d_ready  <= w_d_done;
         if (w_if_done) r_if_rdata <= bus.mem_rdata;
         if (w_d_done)  r_d_rdata  <= bus.mem_rdata;
         if (w_grant_d) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.d_we;
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
         end else if (w_grant_if) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= bus.if_addr;
            r_mem_wdata <= '0;
         end else if (bus.mem_ack && (r_state != IDLE)) begin
            r_mem_req   <= 1'b0;
         end
      end
   end

   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.if_ready  = r_if_ready;
   assign bus.d_rdata   = r_d_rdata;
   assign bus.d_ready   = r_d_ready;
   assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level reference model feeding a scoreboard.
module tb_mem_port_arbiter;
   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} mem_txn_t;
   typedef struct {int who; logic [31:0] data; bit chk; int cyc;} rdy_t;

   mem_txn_t exp_mem[$];
   rdy_t     exp_rdy[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int mode    = 0;   // 0 quiet, 1 random, 2 drain, 3 single load
   int if_pct  = 50;
   int d_pct   = 50;
   int fl_pct  = 10;
   bit model_en = 1'b0;
   bit chk_en   = 1'b0;

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_event(string name, string what);
      n_tests++;
      n_fail++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   // Requesters and flush source.
   always @(negedge clk) begin
      case (mode)
         1, 2: begin
            if (bus.if_ready || !bus.if_req) begin
               bus.if_req  = (mode == 1) && ($urandom_range(0, 99) < if_pct);
               bus.if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (bus.d_ready || !bus.d_req) begin
               bus.d_req   = (mode == 1) && ($urandom_range(0, 99) < d_pct);
               bus.d_we    = $urandom_range(0, 1) == 1;
               bus.d_addr  = $urandom & 32'hFFFF_FFFC;
               bus.d_wdata = $urandom;
            end
            bus.flush = (mode == 1) && ($urandom_range(0, 99) < fl_pct);
            if (bus.flush) bus.if_addr = $urandom & 32'hFFFF_FFFC;
         end
         3: begin
            bus.if_req  = 1'b0;
            bus.if_addr = '0;
            bus.d_req   = 1'b1;
            bus.d_we    = 1'b0;
            bus.d_addr  = 32'h0000_0200;
            bus.d_wdata = '0;
            bus.flush   = 1'b0;
         end
         default: begin
            bus.if_req  = 1'b0;
            bus.if_addr = '0;
            bus.d_req   = 1'b0;
            bus.d_we    = 1'b0;
            bus.d_addr  = '0;
            bus.d_wdata = '0;
            bus.flush   = 1'b0;
         end
      endcase
   end

   // Memory: acks 1..4 cycles after it first sees mem_req.
   bit txn_active = 1'b0;
   int wait_cnt   = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         txn_active    = 1'b0;
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = '0;
      end else begin
         bus.mem_ack = 1'b0;
         if (txn_active) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = $urandom;
               txn_active    = 1'b0;
            end
         end else if (bus.mem_req) begin
            txn_active = 1'b1;
            wait_cnt   = $urandom_range(1, 4);
         end
      end
   end

   // Reference model: one outstanding transaction, owner, drop flag, starvation tally.
   bit m_busy  = 1'b0;
   int m_owner = 0;
   bit m_drop  = 1'b0;
   bit m_d_we  = 1'b0;
   int m_starve = 0;
   bit m_if_rdy = 1'b0;
   bit m_d_rdy  = 1'b0;
   bit ie, de, nif, nd;
   always @(posedge clk) begin
      if (model_en) begin
         nif = 1'b0;
         nd  = 1'b0;
         if (!m_busy) begin
            ie = bus.if_req && !m_if_rdy;
            de = bus.d_req && !m_d_rdy;
            if (de && (!ie || m_starve < STARVE_MAX)) begin
               exp_mem.push_back('{bus.d_we, bus.d_addr, bus.d_wdata});
               m_busy  = 1'b1;
               m_owner = 2;
               m_d_we  = bus.d_we;
               if (bus.if_req && m_starve < STARVE_MAX) m_starve++;
            end else if (ie && !bus.flush) begin
               exp_mem.push_back('{1'b0, bus.if_addr, 32'h0});
               m_busy   = 1'b1;
               m_owner  = 1;
               m_starve = 0;
            end
         end else begin
            if (m_owner == 1 && bus.flush) m_drop = 1'b1;
            if (bus.mem_ack) begin
               if (m_owner == 2) begin
                  exp_rdy.push_back('{2, bus.mem_rdata, !m_d_we, cyc + 1});
                  nd = 1'b1;
               end else if (!m_drop) begin
                  exp_rdy.push_back('{1, bus.mem_rdata, 1'b1, cyc + 1});
                  nif = 1'b1;
               end
               m_busy  = 1'b0;
               m_drop  = 1'b0;
               m_owner = 0;
            end
         end
         if (!bus.if_req) m_starve = 0;
         m_if_rdy = nif;
         m_d_rdy  = nd;
         cyc++;
      end
   end

   task automatic got_ready(int who, logic [31:0] data);
      rdy_t e;
      if (exp_rdy.size() == 0) begin
         fail_event("ready_unexpected", $sformatf("actual pulse from requester %0d, required none", who));
      end else begin
         e = exp_rdy.pop_front();
         check("ready_who", who, e.who);
         check("ready_cycle", cyc, e.cyc);
         if (e.chk) check("ready_rdata", data, e.data);
      end
   endtask

   // Monitor: compares DUT activity against the expectation queues.
   logic prev_req = 1'b0;
   mem_txn_t t;
   always @(negedge clk) begin
      if (chk_en) begin
         while (exp_rdy.size() > 0 && exp_rdy[0].cyc < cyc) begin
            fail_event("ready_missing", $sformatf("actual none, required pulse from requester %0d", exp_rdy[0].who));
            void'(exp_rdy.pop_front());
         end
         if (bus.mem_req && !prev_req) begin
            if (exp_mem.size() == 0) begin
               fail_event("grant_unexpected", $sformatf("actual mem_req addr %0h, required none", bus.mem_addr));
            end else begin
               t = exp_mem.pop_front();
               check("grant_we", bus.mem_we, t.we);
               check("grant_addr", bus.mem_addr, t.addr);
               if (t.we) check("grant_wdata", bus.mem_wdata, t.wdata);
            end
         end
         if (bus.if_ready && bus.d_ready) fail_event("ready_overlap", "actual both readys high, required at most one");
         if (bus.if_ready) got_ready(1, bus.if_rdata);
         if (bus.d_ready)  got_ready(2, bus.d_rdata);
         check("busy", bus.busy, m_busy);
         check("mem_req_level", bus.mem_req, m_busy);
      end
      prev_req = bus.mem_req;
   end

   initial begin
      bit drained;
      mode = 0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_mem_req", bus.mem_req, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_if_ready", bus.if_ready, 0);
      check("reset_d_ready", bus.d_ready, 0);
      check("reset_mem_addr", bus.mem_addr, 0);
      check("reset_if_rdata", bus.if_rdata, 0);
      rst_n    = 1'b1;
      model_en = 1'b1;
      chk_en   = 1'b1;

      mode = 1;
      if_pct = 60; d_pct = 60; fl_pct = 10;
      repeat (1500) @(negedge clk);
      if_pct = 90; d_pct = 90; fl_pct = 50;
      repeat (1500) @(negedge clk);
      if_pct = 30; d_pct = 80; fl_pct = 25;
      repeat (1000) @(negedge clk);

      mode = 2;
      drained = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!bus.busy && !bus.if_req && !bus.d_req && exp_rdy.size() == 0) begin
            drained = 1'b1;
            break;
         end
      end
      repeat (3) @(negedge clk);
      check("drain_done", drained, 1);
      check("drain_exp_mem_empty", exp_mem.size(), 0);
      check("drain_exp_rdy_empty", exp_rdy.size(), 0);

      chk_en   = 1'b0;
      model_en = 1'b0;
      mode = 3;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.mem_req) break;
      end
      check("rst_pre_busy", bus.busy, 1);
      check("rst_pre_mem_we", bus.mem_we, 0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_mem_req", bus.mem_req, 0);
      check("rst_async_busy", bus.busy, 0);
      check("rst_async_d_ready", bus.d_ready, 0);
      check("rst_async_mem_addr", bus.mem_addr, 0);
      mode = 0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
